// File: rtl/inst_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : inst_queue_if
// Description : Fetcher/decoder/ROB-facing signal bundle of the instruction
//               queue. The slave modport is the queue side; the master modport
//               is the side that drives pushes, issues and flushes.
// Revision    : 1.0 - initial release
// ============================================================================
interface inst_queue_if #(
  parameter int DEPTH_BIT = 3
);
  logic                 push_valid;
  logic [31:0]          push_inst;
  logic [31:0]          push_addr;
  logic                 push_ready;
  logic                 wrong_predicted;
  logic                 issue_signal;
  logic                 start_decoder;
  logic                 valid;
  logic [31:0]          inst;
  logic [31:0]          inst_addr;
  logic [DEPTH_BIT:0]   count;

  modport slave (
    input  push_valid, push_inst, push_addr, wrong_predicted, issue_signal,
    output push_ready, start_decoder, valid, inst, inst_addr, count
  );

  modport master (
    output push_valid, push_inst, push_addr, wrong_predicted, issue_signal,
    input  push_ready, start_decoder, valid, inst, inst_addr, count
  );
endinterface
`default_nettype wire

// File: rtl/inst_queue.sv
`default_nettype none
// ============================================================================
// Module      : inst_queue
// Description : Circular instruction FIFO between fetcher and decoder. Presents
//               the oldest entry to the decoder, pops on issue_signal, flushes
//               on wrong_predicted and back-pressures the fetcher.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_queue #(
  parameter int DEPTH_BIT = 3
) (
  input  wire logic      clk_in,
  input  wire logic      rst_in,
  input  wire logic      rdy_in,
  inst_queue_if.slave    q
);

  localparam int                  c_DEPTH_N = 1 << DEPTH_BIT;
  localparam logic [DEPTH_BIT:0]  c_DEPTH   = {1'b1, {DEPTH_BIT{1'b0}}};
  localparam logic [DEPTH_BIT-1:0] c_PTR_ONE = 1;
  localparam logic [DEPTH_BIT:0]  c_CNT_ONE = 1;

  localparam logic [0:0] c_ST_RUN   = 1'b0;
  localparam logic [0:0] c_ST_FLUSH = 1'b1;

  logic [0:0]           r_state;
  logic [0:0]           w_state_nxt;
  logic [DEPTH_BIT-1:0] r_head;
  logic [DEPTH_BIT-1:0] r_tail;
  logic [DEPTH_BIT:0]   r_count;
  logic [31:0]          r_mem_inst [0:c_DEPTH_N-1];
  logic [31:0]          r_mem_addr [0:c_DEPTH_N-1];

  logic w_flush;
  logic w_push;
  logic w_pop;
  logic w_valid;
  logic w_start_decoder;
  logic w_push_ready;

  // Qualified events; a flush in the same cycle discards any push or pop.
  assign w_flush = rdy_in && q.wrong_predicted;
  assign w_push  = q.push_valid && w_push_ready && !w_flush;
  assign w_pop   = q.issue_signal && w_valid && w_start_decoder && !w_flush;

  // State register: RUN after reset.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) r_state <= c_ST_RUN;
    else         r_state <= w_state_nxt;
  end

  // Next state: enter or stay in FLUSH while a qualified flush is present;
  // everything holds while rdy_in is low.
  always_comb begin
    w_state_nxt = r_state;
    if (rdy_in) begin
      case (r_state)
        c_ST_RUN:   if (w_flush)  w_state_nxt = c_ST_FLUSH;
        c_ST_FLUSH: if (!w_flush) w_state_nxt = c_ST_RUN;
        default:    w_state_nxt = c_ST_RUN;
      endcase
    end
  end

  // Output decode: handshake qualifiers depend on state, occupancy and rdy_in.
  always_comb begin
    w_valid         = (r_count != '0);
    w_start_decoder = rdy_in && (r_state == c_ST_RUN);
    w_push_ready    = rdy_in && (r_state == c_ST_RUN) && (r_count < c_DEPTH);
  end

  // Pointers and occupancy; flush has priority and rdy_in low freezes them.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (rdy_in) begin
      if (w_flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) r_tail <= r_tail + c_PTR_ONE;
        if (w_pop)  r_head <= r_head + c_PTR_ONE;
        if (w_push && !w_pop)      r_count <= r_count + c_CNT_ONE;
        else if (w_pop && !w_push) r_count <= r_count - c_CNT_ONE;
      end
    end
  end

  // Entry storage: written only on an accepted push, never cleared.
  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_mem_inst[r_tail] <= q.push_inst;
      r_mem_addr[r_tail] <= q.push_addr;
    end
  end

  assign q.valid         = w_valid;
  assign q.start_decoder = w_start_decoder;
  assign q.push_ready    = w_push_ready;
  assign q.count         = r_count;
  assign q.inst          = w_valid ? r_mem_inst[r_head] : 32'h0;
  assign q.inst_addr     = w_valid ? r_mem_addr[r_head] : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_inst_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_queue
// Description : Self-checking bench for inst_queue. A queue-based reference
//               model predicts every output each cycle under directed and
//               random stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_queue;

  localparam int DEPTH_BIT = 3;
  localparam int DEPTH     = 1 << DEPTH_BIT;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic rdy_in = 1'b1;

  always #5 clk_in = ~clk_in;

  inst_queue_if #(.DEPTH_BIT(DEPTH_BIT)) q_if ();

  inst_queue #(.DEPTH_BIT(DEPTH_BIT)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .q      (q_if.slave)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  string       phase = "init";
  logic [63:0] m_q[$];     // {inst, addr}, oldest at index 0
  bit          m_flush = 1'b0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s/%s: got %0h expected %0h", phase, tag, act, exp);
    end
  endtask

  task automatic check_outputs();
    logic [63:0] h;
    h = (m_q.size() != 0) ? m_q[0] : 64'h0;
    check("count", 64'(q_if.count), 64'(m_q.size()));
    check("valid", 64'(q_if.valid), 64'(m_q.size() != 0));
    check("push_ready", 64'(q_if.push_ready), 64'(rdy_in && !m_flush && m_q.size() < DEPTH));
    check("start_decoder", 64'(q_if.start_decoder), 64'(rdy_in && !m_flush));
    check("inst", 64'(q_if.inst), 64'(h[63:32]));
    check("inst_addr", 64'(q_if.inst_addr), 64'(h[31:0]));
  endtask

  // One clock cycle: drive, check combinational outputs, then advance model.
  task automatic step(input bit rdy, input bit pv, input logic [31:0] pi,
                      input logic [31:0] pa, input bit wp, input bit iss);
    bit do_push, do_pop;
    rdy_in               = rdy;
    q_if.push_valid      = pv;
    q_if.push_inst       = pi;
    q_if.push_addr       = pa;
    q_if.wrong_predicted = wp;
    q_if.issue_signal    = iss;
    #1;
    check_outputs();
    do_pop  = iss && (m_q.size() != 0) && !m_flush;
    do_push = pv && !m_flush && (m_q.size() < DEPTH);
    @(posedge clk_in);
    if (rdy) begin
      if (wp) begin
        m_q.delete();
        m_flush = 1'b1;
      end else begin
        if (do_pop)  void'(m_q.pop_front());
        if (do_push) m_q.push_back({pi, pa});
        m_flush = 1'b0;
      end
    end
    @(negedge clk_in);
  endtask

  initial begin
    q_if.push_valid      = 1'b0;
    q_if.push_inst       = '0;
    q_if.push_addr       = '0;
    q_if.wrong_predicted = 1'b0;
    q_if.issue_signal    = 1'b0;

    // Reset state
    phase = "reset";
    @(negedge clk_in);
    @(negedge clk_in);
    #1;
    check_outputs();
    rst_in = 1'b1;
    @(negedge clk_in);

    // Fill to full, then a rejected 9th push
    phase = "fill";
    for (int k = 0; k < DEPTH; k++) step(1, 1, 32'h13, 32'(k * 4), 0, 0);
    step(1, 1, 32'hDEAD0013, 32'h20, 0, 0);
    step(1, 0, 0, 0, 0, 0);

    // Full with pop: the push is still rejected
    phase = "full_pop";
    step(1, 1, 32'hBEEF0013, 32'h24, 0, 1);

    // Drain to 3, then simultaneous push/pop and drain out
    phase = "push_pop";
    while (m_q.size() > 3) step(1, 0, 0, 0, 0, 1);
    step(1, 1, 32'h00400013, 32'h40, 0, 1);
    for (int k = 0; k < 4; k++) step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);

    // Wrap-around with interleaved push/pop
    phase = "wrap";
    for (int k = 0; k < 12; k++) begin
      step(1, 1, 32'h1000 + 32'(k), 32'h100 + 32'(4 * k), 0, 1);
      check("count_le_1", 64'(q_if.count <= 1), 64'd1);
    end
    step(1, 0, 0, 0, 0, 1);

    // Flush with push and issue in the same cycle
    phase = "flush";
    for (int k = 0; k < 4; k++) step(1, 1, 32'h2000 + 32'(k), 32'h300 + 32'(4 * k), 0, 0);
    step(1, 1, 32'h2222, 32'h310, 1, 1);
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 32'h00200013, 32'h200, 0, 0);
    step(1, 0, 0, 0, 0, 0);

    // Pause: rdy_in low ignores push, issue and flush
    phase = "pause";
    step(1, 1, 32'h3000, 32'h400, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 1, 32'h3333, 32'h500, 1, 1);
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);

    // Asynchronous reset mid-cycle with five entries queued
    phase = "mid_reset";
    for (int k = 0; k < 5; k++) step(1, 1, 32'h4000 + 32'(k), 32'h600 + 32'(4 * k), 0, 0);
    q_if.push_valid = 1'b0;
    #2;
    rst_in = 1'b0;
    #1;
    check("count_async", 64'(q_if.count), 64'd0);
    check("valid_async", 64'(q_if.valid), 64'd0);
    check("inst_async", 64'(q_if.inst), 64'd0);
    m_q.delete();
    m_flush = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
    step(1, 0, 0, 0, 0, 0);

    // Random traffic
    phase = "random";
    for (int n = 0; n < 800; n++) begin
      step(($urandom_range(0, 9) != 0),
           ($urandom_range(0, 9) < 7),
           $urandom(),
           $urandom(),
           ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 9) < 6));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inst_queue.md
# inst_queue

Eight-entry (parameterisable) instruction FIFO and issue sequencer between the instruction fetcher and the decoder. It buffers fetched instruction/address pairs and presents the oldest one to the decoder with `start_decoder`/`valid`. It pops on the decoder's `issue_signal`, flushes on `wrong_predicted` from the ROB, and back-pressures the fetcher through `push_ready`. All resource checks (ROB/RS/LSB full, JALR stall) remain in the decoder; this block only observes the resulting `issue_signal`.

## Interface
- `DEPTH_BIT`, 3, log2 of queue depth; DEPTH = 2^DEPTH_BIT.
- `clk_in` input 1: system clock.
- `rst_in` input 1: asynchronous, active-low reset.
- `rdy_in` input 1: global ready; when low, all state holds.
- `push_valid` input 1: fetcher presents an instruction.
- `push_inst` input 32: fetched instruction word.
- `push_addr` input 32: fetched instruction address.
- `push_ready` output 1: queue accepts a push this cycle.
- `wrong_predicted` input 1: ROB flush request.
- `issue_signal` input 1: decoder issued the head entry this cycle.
- `start_decoder` output 1: decoder may evaluate the head.
- `valid` output 1: head entry is valid (queue non-empty).
- `inst` output 32: head instruction word.
- `inst_addr` output 32: head instruction address.
- `count` output DEPTH_BIT+1: current occupancy.

## Operation
- **Storage:** circular buffer with `head`/`tail` pointers (DEPTH_BIT wide, natural wrap from DEPTH-1 to 0) and `count` (0..DEPTH).
- **FSM states:** RUN and FLUSH. Reset state is RUN.
  - RUN → FLUSH on a qualified flush (`rdy_in && wrong_predicted`).
  - FLUSH → RUN after one cycle, unless the flush is still qualified, in which case it stays FLUSH.
- **Push:** accepted when `push_valid && push_ready && rdy_in`. Writes `mem[tail]`, increments `tail`.
- **push_ready:** `state==RUN && count<DEPTH`. There is no full-with-pop bypass, so a push at full is rejected even if a pop occurs in the same cycle.
- **Pop:** when `issue_signal && valid && start_decoder && rdy_in`, increment `head`. `issue_signal` while empty or in FLUSH is ignored.
- **Simultaneous push and pop:** both pointers advance and `count` is unchanged.
- **Flush:** a qualified flush sets `head=tail=count=0` at the edge. Any push or pop in that same cycle is discarded. Flush has priority over everything.
- **Outputs:**
  - `valid = count!=0`.
  - `start_decoder = state==RUN && rdy_in`.
  - `inst`/`inst_addr` = `mem[head]` when valid, 0 otherwise.
- **rdy_in low:** pointers, count, FSM and memory hold. `start_decoder` and `push_ready` drive low. `wrong_predicted` is ignored.
- **Reset (asynchronous, mid-operation allowed):** `head=tail=count=0` and state RUN. Resulting outputs: `valid=0`, `inst=0`, `inst_addr=0`, `start_decoder=rdy_in`, `push_ready=rdy_in`. Memory contents need not be cleared.

## Timing
- A pushed entry is visible at `inst`/`valid` on the cycle after the push edge (1-cycle fill latency). There is no same-cycle pass-through.
- Head outputs are combinational from registered state. The decoder samples `inst` in the same cycle it asserts `issue_signal`. The next head appears right after the pop edge.
- Throughput: one push and one pop per cycle sustained.
- Flush: the cycle after a qualified `wrong_predicted`, `valid=0` and `push_ready=0` (FLUSH). The cycle after that, `push_ready=1`, so the fetcher has one cycle to redirect to `correct_pc`.
- `count` is registered and updates on the edge.

## Test plan
- **Reset:** assert `rst_in=0` mid-cycle with count=5 → immediately `count=0`, `valid=0`, `inst=0`. Release with `rdy_in=1` → `push_ready=1`, `start_decoder=1`.
- **Fill:** push 8 entries (addr 0x0..0x1C, inst 0x00000013), no pops → `count=8`, `push_ready=0`. A 9th push is not stored, and the head remains addr 0x0.
- **Simultaneous push/pop:** at count=3, push addr 0x40 and pop in the same cycle → `count` stays 3. The head advances to the next-oldest entry; 0x40 is popped third after that.
- **Wrap-around:** 12 interleaved push/pop pairs with addresses 0x100+4k → popped addresses appear strictly in order across the pointer wrap, and `count` never exceeds 1.
- **Flush:** at count=4, assert `wrong_predicted` with `push_valid=1` and `issue_signal=1` → next cycle `count=0`, `valid=0`, `push_ready=0`, `start_decoder=0`. One cycle later `push_ready=1`, and a new push of addr 0x200 is at the head one cycle after that.
- **Pause:** hold `rdy_in=0` for 3 cycles with `push_valid`, `issue_signal` and `wrong_predicted` all high → `count`, head and tail are unchanged, and `start_decoder=0`. After `rdy_in` returns high, normal operation resumes.
